// File: rtl/loop_ctrl.sv
// loop_ctrl: bracket-loop sequencer driving the return-address stack and PC redirects.
// Define LOOP_CTRL_STATS_EN to build the loop_iters jump counter (otherwise tied to 0).
module loop_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 16,
  parameter int NEST_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_open,
  input  logic              cell_zero,
  input  logic [ADDR_W-1:0] op_pc,
  output logic              op_ready,
  output logic              skip_active,
  input  logic              skip_valid,
  input  logic              skip_open,
  input  logic              skip_close,
  input  logic [ADDR_W-1:0] skip_pc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] stk_pushd,
  output logic              stk_push_en,
  output logic              stk_pop_en,
  input  logic [ADDR_W-1:0] stk_top,
  output logic              error,
  output logic [31:0]       loop_iters
);

  localparam int OCC_W = $clog2(STACK_DEPTH + 1);
  localparam logic [OCC_W-1:0]  OCC_MAX  = OCC_W'(STACK_DEPTH);
  localparam logic [NEST_W-1:0] NEST_MAX = '1;
  localparam logic [NEST_W-1:0] NEST_ONE = NEST_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_SKIP,
    S_JUMP,
    S_POP,
    S_ERR
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;
  logic [NEST_W-1:0] nest_q;
  logic [NEST_W-1:0] nest_d;

  logic              op_ready_d;
  logic              skip_d;
  logic              error_d;
  logic              pc_load_d;
  logic [ADDR_W-1:0] pc_next_d;
  logic [ADDR_W-1:0] pushd_d;
  logic              push_d;
  logic              pop_d;
  logic              fault;

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    nest_d     = nest_q;
    op_ready_d = op_ready;
    skip_d     = skip_active;
    error_d    = error;
    pc_load_d  = 1'b0;
    pc_next_d  = pc_next;
    pushd_d    = stk_pushd;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        op_ready_d = 1'b1;
        if (op_valid && op_ready) begin
          op_ready_d = 1'b0;
          unique case (1'b1)
            op_open && !cell_zero: begin
              if (occ_q < OCC_MAX) begin
                push_d  = 1'b1;
                pushd_d = op_pc;
                occ_d   = occ_q + OCC_W'(1);
                state_d = S_PUSH;
              end else begin
                fault = 1'b1;
              end
            end
            op_open && cell_zero: begin
              nest_d  = NEST_ONE;
              skip_d  = 1'b1;
              state_d = S_SKIP;
            end
            !op_open && !cell_zero: begin
              if (occ_q != '0) begin
                pc_load_d = 1'b1;
                pc_next_d = stk_top + ADDR_W'(1);
                state_d   = S_JUMP;
              end else begin
                fault = 1'b1;
              end
            end
            default: begin
              if (occ_q != '0) begin
                pop_d   = 1'b1;
                occ_d   = occ_q - OCC_W'(1);
                state_d = S_POP;
              end else begin
                fault = 1'b1;
              end
            end
          endcase
        end
      end

      S_PUSH, S_JUMP, S_POP: begin
        op_ready_d = 1'b1;
        state_d    = S_IDLE;
      end

      S_SKIP: begin
        if (skip_valid) begin
          unique case (1'b1)
            skip_open && !skip_close: begin
              if (nest_q == NEST_MAX) begin
                fault = 1'b1;
              end else begin
                nest_d = nest_q + NEST_ONE;
              end
            end
            skip_close && !skip_open: begin
              if (nest_q > NEST_ONE) begin
                nest_d = nest_q - NEST_ONE;
              end else begin
                pc_load_d  = 1'b1;
                pc_next_d  = skip_pc + ADDR_W'(1);
                skip_d     = 1'b0;
                nest_d     = '0;
                op_ready_d = 1'b1;
                state_d    = S_IDLE;
              end
            end
            // both brackets at once is malformed input: hold
            default: ;
          endcase
        end
      end

      S_ERR: begin
        op_ready_d = 1'b0;
        skip_d     = 1'b0;
        error_d    = 1'b1;
      end

      default: fault = 1'b1;
    endcase

    if (fault) begin
      state_d    = S_ERR;
      error_d    = 1'b1;
      op_ready_d = 1'b0;
      skip_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      occ_q       <= '0;
      nest_q      <= '0;
      op_ready    <= 1'b0;
      skip_active <= 1'b0;
      error       <= 1'b0;
      pc_load     <= 1'b0;
      pc_next     <= '0;
      stk_pushd   <= '0;
      stk_push_en <= 1'b0;
      stk_pop_en  <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      nest_q      <= nest_d;
      op_ready    <= op_ready_d;
      skip_active <= skip_d;
      error       <= error_d;
      pc_load     <= pc_load_d;
      pc_next     <= pc_next_d;
      stk_pushd   <= pushd_d;
      stk_push_en <= push_d;
      stk_pop_en  <= pop_d;
    end
  end

`ifdef LOOP_CTRL_STATS_EN
  // JUMP is only ever entered on a successful back-jump
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loop_iters <= '0;
    end else if (state_q == S_JUMP) begin
      loop_iters <= loop_iters + 32'd1;
    end
  end
`else
  assign loop_iters = '0;
`endif

endmodule

// File: doc/loop_ctrl.md
Name: loop_ctrl

Overview:
- Sequences the return-address stack (16-bit push/pop stack, `pushd`/`push_en`/`pop_en`/`top`) for the processor's `[` and `]` instructions.
- Takes decoded loop ops from the decoder. Decides push, pop, jump-back or forward-skip.
- Drives PC redirects to the fetch unit.
- Tracks stack occupancy so overflow and underflow are flagged instead of silently corrupting state.

Parameters:
- ADDR_W, 16, PC / stack entry width; must equal the stack data width.
- STACK_DEPTH, 16, number of stack entries; occupancy limit.
- NEST_W, 8, width of the forward-skip nesting counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op_valid  in  1  decoder presents a loop op
- op_open  in  1  1 = `[`, 0 = `]`
- cell_zero  in  1  current data cell == 0, sampled with op
- op_pc  in  ADDR_W  address of the bracket instruction
- op_ready  out  1  controller can accept an op
- skip_active  out  1  fetch streams instructions for scanning
- skip_valid  in  1  scanned instruction present
- skip_open  in  1  scanned instruction is `[`
- skip_close  in  1  scanned instruction is `]`
- skip_pc  in  ADDR_W  address of scanned instruction
- pc_load  out  1  one-cycle pulse: fetch loads pc_next
- pc_next  out  ADDR_W  redirect target
- stk_pushd  out  ADDR_W  to stack pushd
- stk_push_en  out  1  to stack push_en
- stk_pop_en  out  1  to stack pop_en
- stk_top  in  ADDR_W  from stack top
- error  out  1  sticky overflow/underflow/nesting fault

Behaviour:
- All outputs are registered.
- rst low, asynchronously:
  - state = IDLE, occupancy = 0, nest = 0.
  - error = 0, op_ready = 0.
  - pc_load, pc_next, stk_* and skip_active = 0.
- First cycle after release: op_ready = 1.
- Reset asserted mid-operation aborts immediately; no partial push/pop survives.
- Op acceptance: an op is accepted on a rising edge with op_valid & op_ready. op_ready drops the following cycle.
- States:
  - IDLE: op_ready = 1. On accept, go to PUSH, SKIP, JUMP or POP (per the four cases below).
  - PUSH (`[`, cell != 0): one cycle.
    - If occupancy < STACK_DEPTH: stk_push_en = 1, stk_pushd = op_pc, occupancy + 1, then IDLE.
    - Else: no push, error = 1, go to ERR.
  - JUMP (`]`, cell != 0): one cycle.
    - If occupancy > 0: pc_load = 1, pc_next = stk_top + 1 (mod 2^ADDR_W), stack unchanged, then IDLE.
    - Else: error, go to ERR.
  - POP (`]`, cell == 0): one cycle.
    - If occupancy > 0: stk_pop_en = 1, occupancy − 1, then IDLE.
    - Else: error, go to ERR.
    - No pc_load; fetch falls through.
  - SKIP (`[`, cell == 0): entered with nest = 1; skip_active = 1. Each cycle with skip_valid:
    - open & !close: nest + 1. If nest is at 2^NEST_W − 1: error, go to ERR.
    - close & !open, nest > 1: nest − 1.
    - close & !open, nest == 1: pc_load = 1 next cycle, pc_next = skip_pc + 1, skip_active = 0, nest = 0, go to IDLE.
    - open & close together: illegal; ignored, nest unchanged.
    - skip_valid low: hold.
    - Stack untouched throughout.
  - ERR: op_ready = 0, skip_active = 0, error = 1. Held until reset.
- Latency:
  - Accept at edge N → stk_push_en, stk_pop_en or pc_load high during cycle N+1.
  - op_ready high again at N+2.
  - Sustained throughput is one loop op per 2 cycles.
- stk_push_en and stk_pop_en are never high in the same cycle. Each is high for at most one cycle per op.
- pc_load is a single-cycle pulse. pc_next holds its value until the next load.

Optional Feature:
- LOOP_CTRL_STATS_EN defined: adds output port loop_iters (32 bits).
  - Increments on every JUMP with pc_load.
  - Cleared by reset; wraps at 2^32.
- Not defined: the port is still present and tied to 0; no counter logic is built.

Test Plan:
- Reset, then `[` at op_pc=16'h0010 with cell nonzero:
  - Cycle N+1: stk_push_en=1, stk_pushd=16'h0010.
  - Then `]` with cell nonzero and stk_top=16'h0010: pc_load=1, pc_next=16'h0011.
- Push 16'hBEEF and 16'hDEAD, then two `]` with cell_zero:
  - Two stk_pop_en pulses, occupancy back to 0.
  - A third `]` raises error; op_ready stays 0.
- `[` with cell_zero at 16'h0020:
  - skip_active=1.
  - Feed open@0x21, close@0x25, close@0x30 → pc_load with pc_next=16'h0031, skip_active=0, no stack activity.
- STACK_DEPTH+1 consecutive nonzero `[`:
  - First 16 push.
  - 17th: no stk_push_en, error=1.
- Drive rst low during SKIP and during PUSH:
  - All outputs 0 immediately.
  - After release: op_ready=1, error=0.
- With LOOP_CTRL_STATS_EN: three nonzero `]` jumps → loop_iters=3.
- Without LOOP_CTRL_STATS_EN: loop_iters=0.
